// File: rtl/apb_cmd_sequencer.sv
// Command FIFO front-end for apb_top: queues host requests and issues them one at a time.
// Define APB_SEQ_TIMEOUT_EN to abort commands that wait TIMEOUT cycles without ready_i.
module apb_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                     pclk,
  input  logic                     preset,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [1:0]               cmd_i,
  input  logic [31:0]              cmd_wdata_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [1:0]               add_o,
  output logic [31:0]              wdata_o,
  input  logic                     ready_i,
  input  logic [31:0]              rdata_i,
  output logic                     rsp_valid_o,
  output logic                     rsp_write_o,
  output logic [31:0]              rsp_data_o,
  output logic                     rsp_err_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] GAP    = 2'd2;

  logic [1:0]    cmdMem  [DEPTH];
  logic [31:0]   dataMem [DEPTH];

  logic [PW-1:0] wrPtr_q, rdPtr_q;
  logic [LW-1:0] count_q, count_d;
  logic [1:0]    state_q, state_d;
  logic [1:0]    cmd_q, cmd_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          rspValid_q, rspValid_d;
  logic          rspWrite_q, rspWrite_d;
  logic [31:0]   rspData_q, rspData_d;

  logic full, empty, push, store, pop;

  assign full  = (count_q == LW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = cmd_valid_i && !full;
  // Encodings 00/10 complete the handshake but are never stored.
  assign store = push && cmd_i[0];
  assign pop   = ((state_q == IDLE) || (state_q == GAP)) && !empty;

`ifdef APB_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] timer_q, timer_d;
  logic          rspErr_q, rspErr_d;
`endif

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    wdata_d    = wdata_q;
    rspValid_d = 1'b0;
    rspWrite_d = rspWrite_q;
    rspData_d  = rspData_q;
`ifdef APB_SEQ_TIMEOUT_EN
    timer_d    = timer_q;
    rspErr_d   = rspErr_q;
`endif
    case (state_q)
      IDLE, GAP: begin
        if (pop) begin
          state_d = ACTIVE;
          cmd_d   = cmdMem[rdPtr_q];
          wdata_d = dataMem[rdPtr_q];
`ifdef APB_SEQ_TIMEOUT_EN
          timer_d = '0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      ACTIVE: begin
        if (ready_i) begin
          state_d    = GAP;
          rspValid_d = 1'b1;
          rspWrite_d = (cmd_q == 2'b11);
          rspData_d  = (cmd_q == 2'b11) ? 32'd0 : rdata_i;
`ifdef APB_SEQ_TIMEOUT_EN
          rspErr_d   = 1'b0;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          // Last permitted ACTIVE cycle with no ready: abort with an error response.
          state_d    = GAP;
          rspValid_d = 1'b1;
          rspWrite_d = (cmd_q == 2'b11);
          rspData_d  = 32'd0;
          rspErr_d   = 1'b1;
        end else begin
          timer_d    = timer_q + TW'(1);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({store, pop})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (store) begin
      cmdMem[wrPtr_q]  <= cmd_i;
      dataMem[wrPtr_q] <= cmd_wdata_i;
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q    <= IDLE;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      cmd_q      <= 2'b00;
      wdata_q    <= '0;
      rspValid_q <= 1'b0;
      rspWrite_q <= 1'b0;
      rspData_q  <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      cmd_q      <= cmd_d;
      wdata_q    <= wdata_d;
      rspValid_q <= rspValid_d;
      rspWrite_q <= rspWrite_d;
      rspData_q  <= rspData_d;
      if (store) wrPtr_q <= wrPtr_q + PW'(1);
      if (pop)   rdPtr_q <= rdPtr_q + PW'(1);
    end
  end

`ifdef APB_SEQ_TIMEOUT_EN
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      timer_q  <= '0;
      rspErr_q <= 1'b0;
    end else begin
      timer_q  <= timer_d;
      rspErr_q <= rspErr_d;
    end
  end
  assign rsp_err_o = rspErr_q;
`else
  assign rsp_err_o = 1'b0;
`endif

  // Decoding add_o from state lets reset force a NOP without waiting for a clock.
  assign add_o       = (state_q == ACTIVE) ? cmd_q : 2'b00;
  assign wdata_o     = wdata_q;
  assign cmd_ready_o = !full;
  assign level_o     = count_q;
  assign rsp_valid_o = rspValid_q;
  assign rsp_write_o = rspWrite_q;
  assign rsp_data_o  = rspData_q;

endmodule

// File: tb/tb_apb_cmd_sequencer.sv
// Self-checking bench for apb_cmd_sequencer: directed vector table, corner sequences,
// and random traffic compared every cycle against a queue-based reference model.
module tb_apb_cmd_sequencer;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
  localparam int LW      = $clog2(DEPTH) + 1;

  logic          pclk;
  logic          preset;
  logic          cmdValid;
  logic [1:0]    cmdIn;
  logic [31:0]   cmdWdata;
  logic          readyIn;
  logic [31:0]   rdataIn;
  logic          cmdReadyO;
  logic [LW-1:0] levelO;
  logic [1:0]    addO;
  logic [31:0]   wdataO;
  logic          rspValidO;
  logic          rspWriteO;
  logic [31:0]   rspDataO;
  logic          rspErrO;

  apb_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .pclk        (pclk),
    .preset      (preset),
    .cmd_valid_i (cmdValid),
    .cmd_ready_o (cmdReadyO),
    .cmd_i       (cmdIn),
    .cmd_wdata_i (cmdWdata),
    .level_o     (levelO),
    .add_o       (addO),
    .wdata_o     (wdataO),
    .ready_i     (readyIn),
    .rdata_i     (rdataIn),
    .rsp_valid_o (rspValidO),
    .rsp_write_o (rspWriteO),
    .rsp_data_o  (rspDataO),
    .rsp_err_o   (rspErrO)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int errCount = 0;
  int checkCount = 0;

  // Reference model: a queue of pending commands plus the single command in flight.
  typedef struct packed {
    logic [1:0]  cmd;
    logic [31:0] data;
  } entry_t;

  entry_t      mq[$];
  bit          mBusy;
  logic [1:0]  mCmd;
  logic [31:0] mWdata;
  int          mActive;
  bit          eRspValid, eRspWrite, eRspErr;
  logic [31:0] eRspData;
  int          mAccepted;

  typedef struct {
    logic        valid;
    logic [1:0]  cmd;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;
    logic [1:0]  expAdd;
    int          expLevel;
    logic        expRspValid;
    logic        expRspWrite;
    logic [31:0] expRspData;
    logic [31:0] expWdata;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  function automatic vec_t mkVec(input logic v, input logic [1:0] c, input logic [31:0] w,
                                 input logic r, input logic [31:0] rd, input logic [1:0] ea,
                                 input int el, input logic erv, input logic erw,
                                 input logic [31:0] erd, input logic [31:0] ew);
    vec_t t;
    t.valid = v; t.cmd = c; t.wdata = w; t.ready = r; t.rdata = rd;
    t.expAdd = ea; t.expLevel = el; t.expRspValid = erv; t.expRspWrite = erw;
    t.expRspData = erd; t.expWdata = ew;
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    mBusy     = 1'b0;
    mCmd      = 2'b00;
    mWdata    = 32'd0;
    mActive   = 0;
    eRspValid = 1'b0;
    eRspWrite = 1'b0;
    eRspErr   = 1'b0;
    eRspData  = 32'd0;
  endtask

  // One clock edge of the model, using the inputs that were stable before the edge.
  task automatic modelStep();
    bit     accept;
    entry_t e;
    accept    = cmdValid && (mq.size() != DEPTH);
    eRspValid = 1'b0;
    if (mBusy) begin
      if (readyIn) begin
        eRspValid = 1'b1;
        eRspWrite = (mCmd == 2'b11);
        eRspData  = eRspWrite ? 32'd0 : rdataIn;
        eRspErr   = 1'b0;
        mBusy     = 1'b0;
      end
`ifdef APB_SEQ_TIMEOUT_EN
      else if (mActive == TIMEOUT) begin
        eRspValid = 1'b1;
        eRspWrite = (mCmd == 2'b11);
        eRspData  = 32'd0;
        eRspErr   = 1'b1;
        mBusy     = 1'b0;
      end else begin
        mActive++;
      end
`endif
    end else if (mq.size() != 0) begin
      e       = mq.pop_front();
      mCmd    = e.cmd;
      mWdata  = e.data;
      mBusy   = 1'b1;
      mActive = 1;
    end
    if (accept) begin
      mAccepted++;
      if (cmdIn[0]) begin
        e.cmd  = cmdIn;
        e.data = cmdWdata;
        mq.push_back(e);
      end
    end
  endtask

  task automatic checkModel();
    checkOutput("add_o", 32'(addO), 32'(mBusy ? mCmd : 2'b00));
    checkOutput("wdata_o", wdataO, mWdata);
    checkOutput("level_o", 32'(levelO), 32'(mq.size()));
    checkOutput("cmd_ready_o", 32'(cmdReadyO), 32'(mq.size() != DEPTH));
    checkOutput("rsp_valid_o", 32'(rspValidO), 32'(eRspValid));
    if (eRspValid) begin
      if (!eRspErr) checkOutput("rsp_write_o", 32'(rspWriteO), 32'(eRspWrite));
      checkOutput("rsp_data_o", rspDataO, eRspData);
      checkOutput("rsp_err_o", 32'(rspErrO), 32'(eRspErr));
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] c, input logic [31:0] w,
                               input logic r, input logic [31:0] rd);
    cmdValid = v;
    cmdIn    = c;
    cmdWdata = w;
    readyIn  = r;
    rdataIn  = rd;
  endtask

  task automatic stepCycle();
    @(posedge pclk);
    modelStep();
    #1;
    checkModel();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int dutRsp;
    int dutErr;

    // Directed write then read; ready_i asserted while IDLE must be ignored (row 1).
    vecs[0]  = mkVec(1, 2'b11, 32'hDEADBEEF, 0, 32'h0,        2'b00, 1, 0, 0, 32'h0,        32'h0);
    vecs[1]  = mkVec(0, 2'b00, 32'h0,        1, 32'h55,       2'b11, 0, 0, 0, 32'h0,        32'hDEADBEEF);
    vecs[2]  = mkVec(0, 2'b00, 32'h0,        1, 32'h77,       2'b00, 0, 1, 1, 32'h0,        32'hDEADBEEF);
    vecs[3]  = mkVec(0, 2'b00, 32'h0,        0, 32'h0,        2'b00, 0, 0, 0, 32'h0,        32'hDEADBEEF);
    vecs[4]  = mkVec(1, 2'b01, 32'hAAAA5555, 0, 32'h0,        2'b00, 1, 0, 0, 32'h0,        32'hDEADBEEF);
    vecs[5]  = mkVec(0, 2'b00, 32'h0,        0, 32'h0,        2'b01, 0, 0, 0, 32'h0,        32'hAAAA5555);
    vecs[6]  = mkVec(0, 2'b00, 32'h0,        0, 32'h0,        2'b01, 0, 0, 0, 32'h0,        32'hAAAA5555);
    vecs[7]  = mkVec(0, 2'b00, 32'h0,        0, 32'h0,        2'b01, 0, 0, 0, 32'h0,        32'hAAAA5555);
    vecs[8]  = mkVec(0, 2'b00, 32'h0,        0, 32'h0,        2'b01, 0, 0, 0, 32'h0,        32'hAAAA5555);
    vecs[9]  = mkVec(0, 2'b00, 32'h0,        1, 32'h12345678, 2'b00, 0, 1, 0, 32'h12345678, 32'hAAAA5555);
    vecs[10] = mkVec(1, 2'b10, 32'h1111,     1, 32'h0,        2'b00, 0, 0, 0, 32'h0,        32'hAAAA5555);
    vecs[11] = mkVec(1, 2'b00, 32'h2222,     1, 32'h0,        2'b00, 0, 0, 0, 32'h0,        32'hAAAA5555);
    vecs[12] = mkVec(0, 2'b00, 32'h0,        1, 32'h0,        2'b00, 0, 0, 0, 32'h0,        32'hAAAA5555);

    preset = 1'b1;
    applyStimulus(0, 2'b00, 32'h0, 0, 32'h0);
    modelReset();
    mAccepted = 0;
    repeat (2) @(posedge pclk);
    #1;
    checkOutput("reset add_o", 32'(addO), 32'h0);
    checkOutput("reset wdata_o", wdataO, 32'h0);
    checkOutput("reset cmd_ready_o", 32'(cmdReadyO), 32'h1);
    checkOutput("reset level_o", 32'(levelO), 32'h0);
    checkOutput("reset rsp_valid_o", 32'(rspValidO), 32'h0);
    checkOutput("reset rsp_write_o", 32'(rspWriteO), 32'h0);
    checkOutput("reset rsp_data_o", rspDataO, 32'h0);
    checkOutput("reset rsp_err_o", 32'(rspErrO), 32'h0);
    preset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].cmd, vecs[i].wdata, vecs[i].ready, vecs[i].rdata);
      stepCycle();
      checkOutput($sformatf("vec%0d add_o", i), 32'(addO), 32'(vecs[i].expAdd));
      checkOutput($sformatf("vec%0d level_o", i), 32'(levelO), 32'(vecs[i].expLevel));
      checkOutput($sformatf("vec%0d rsp_valid_o", i), 32'(rspValidO), 32'(vecs[i].expRspValid));
      checkOutput($sformatf("vec%0d wdata_o", i), wdataO, vecs[i].expWdata);
      if (vecs[i].expRspValid) begin
        checkOutput($sformatf("vec%0d rsp_write_o", i), 32'(rspWriteO), 32'(vecs[i].expRspWrite));
        checkOutput($sformatf("vec%0d rsp_data_o", i), rspDataO, vecs[i].expRspData);
      end
    end

    // Fill: one command in flight plus DEPTH queued, with ready_i held low.
    mAccepted = 0;
    for (int i = 0; i < 20 && mAccepted < DEPTH + 1; i++) begin
      applyStimulus(1, (i % 2) ? 2'b01 : 2'b11, $urandom, 0, 32'h0);
      stepCycle();
    end
    checkOutput("fill cmd_ready_o", 32'(cmdReadyO), 32'h0);
    checkOutput("fill level_o", 32'(levelO), 32'(DEPTH));
    applyStimulus(1, 2'b01, 32'hCAFE0000, 0, 32'h0);
    stepCycle();
    checkOutput("full push rejected level_o", 32'(levelO), 32'(DEPTH));

    dutRsp = 0;
    for (int i = 0; i < 40 && dutRsp < DEPTH + 1; i++) begin
      applyStimulus(0, 2'b00, 32'h0, 1, $urandom);
      stepCycle();
      if (rspValidO === 1'b1) dutRsp++;
    end
    checkOutput("drain response count", 32'(dutRsp), 32'(DEPTH + 1));
    repeat (2) begin
      applyStimulus(0, 2'b00, 32'h0, 0, 32'h0);
      stepCycle();
    end

    // Reset while ACTIVE with two commands queued.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 2'b11, 32'h100 + 32'(i), 0, 32'h0);
      stepCycle();
    end
    applyStimulus(0, 2'b00, 32'h0, 0, 32'h0);
    stepCycle();
    checkOutput("pre-reset add_o", 32'(addO), 32'h3);
    checkOutput("pre-reset level_o", 32'(levelO), 32'h2);
    #3;
    preset  = 1'b1;
    readyIn = 1'b1;
    #1;
    checkOutput("async reset add_o", 32'(addO), 32'h0);
    checkOutput("async reset level_o", 32'(levelO), 32'h0);
    checkOutput("async reset rsp_valid_o", 32'(rspValidO), 32'h0);
    checkOutput("async reset cmd_ready_o", 32'(cmdReadyO), 32'h1);
    modelReset();
    @(posedge pclk);
    #1;
    checkOutput("held reset rsp_valid_o", 32'(rspValidO), 32'h0);
    preset = 1'b0;
    applyStimulus(1, 2'b01, 32'h0, 0, 32'h0);
    stepCycle();
    applyStimulus(0, 2'b00, 32'h0, 0, 32'h0);
    stepCycle();
    checkOutput("post-reset read add_o", 32'(addO), 32'h1);
    applyStimulus(0, 2'b00, 32'h0, 1, 32'h0BADF00D);
    stepCycle();
    checkOutput("post-reset read rsp_data_o", rspDataO, 32'h0BADF00D);
    stepCycle();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom), $urandom,
                    ($urandom_range(0, 3) == 0), $urandom);
      stepCycle();
    end
    for (int i = 0; i < 30; i++) begin
      applyStimulus(0, 2'b00, 32'h0, 1, $urandom);
      stepCycle();
    end
    checkOutput("random drain level_o", 32'(levelO), 32'h0);

`ifdef APB_SEQ_TIMEOUT_EN
    // Two commands with ready_i stuck low: first aborts, second follows after one NOP.
    applyStimulus(1, 2'b01, 32'h0, 0, 32'h0);
    stepCycle();
    applyStimulus(1, 2'b11, 32'h5A5A5A5A, 0, 32'h0);
    stepCycle();
    dutErr = 0;
    for (int i = 0; i < 25; i++) begin
      applyStimulus(0, 2'b00, 32'h0, 0, 32'h0);
      stepCycle();
      if (rspValidO === 1'b1 && rspErrO === 1'b1) dutErr++;
    end
    checkOutput("timeout abort count", 32'(dutErr), 32'h1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 2'b00, 32'h0, 1, 32'h0);
      stepCycle();
    end
`else
    dutErr = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/apb_cmd_sequencer.md
# apb_cmd_sequencer

Command front-end that sits directly upstream of `apb_top`. It buffers host read/write requests in a small FIFO and issues them one at a time on the `add_i`/`external_wdata_i` inputs of `apb_top`. For each request it waits for `ready_o`, captures `rdata_o` for reads, and returns one response per completed command. This decouples host request rate from APB slave latency.

## Interface
Parameters:
- `DEPTH`, 4 — command FIFO entries; power of 2, ≥2.
- `TIMEOUT`, 16 — max cycles in ACTIVE before abort; used only with `APB_SEQ_TIMEOUT_EN`; ≥2.

Ports:
- `pclk`  in  1  sole clock; all state updates on rising edge.
- `preset`  in  1  reset; one clock, reset is asynchronous and active-high.
- `cmd_valid_i`  in  1  host request valid.
- `cmd_ready_o`  out  1  FIFO can accept; equals `!full`.
- `cmd_i`  in  2  2'b01 READ, 2'b11 WRITE; 2'b00/2'b10 invalid.
- `cmd_wdata_i`  in  32  write data; stored but ignored for READ.
- `level_o`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `add_o`  out  2  to `apb_top.add_i`.
- `wdata_o`  out  32  to `apb_top.external_wdata_i`.
- `ready_i`  in  1  from `apb_top.ready_o`.
- `rdata_i`  in  32  from `apb_top.rdata_o`.
- `rsp_valid_o`  out  1  one-cycle pulse per completed command.
- `rsp_write_o`  out  1  completed command was a WRITE.
- `rsp_data_o`  out  32  captured read data; 0 for writes and aborts.
- `rsp_err_o`  out  1  command aborted by timeout.

## Operation
- Push: handshake on `cmd_valid_i && cmd_ready_o`.
  - Valid commands are written at the tail.
  - Invalid commands (00/10) complete the handshake but are dropped: no store, no response.
- FIFO: circular, with read/write pointers and an occupancy counter.
  - `level_o` increments on push, decrements on pop, and is unchanged on simultaneous push+pop.
  - `cmd_ready_o` is low when full, even if a pop occurs in the same cycle.
  - No pop when empty.
- FSM states:
  - IDLE: `add_o`=00. If FIFO non-empty: pop head into `cmd_q`/`wdata_q`, go to ACTIVE.
  - ACTIVE: `add_o`=`cmd_q`, `wdata_o`=`wdata_q`, held stable. When `ready_i`=1 is sampled, capture the response and go to GAP.
  - GAP: `add_o`=00 for exactly one cycle. If FIFO non-empty: pop and go to ACTIVE; otherwise go to IDLE.
- Response, registered and asserted the cycle after `ready_i` is sampled:
  - `rsp_valid_o`=1 for that cycle only.
  - `rsp_write_o`=(`cmd_q`==11).
  - `rsp_data_o`=`rdata_i` for READ, else 0.
  - No backpressure: the host must consume the response in that cycle.
- `wdata_o` holds its last value outside ACTIVE. It is 0 after reset.

## Timing
- All outputs are registered or decoded from registered state.
- Reset values:
  - `add_o`=00, `wdata_o`=0, `cmd_ready_o`=1, `level_o`=0.
  - `rsp_valid_o`/`rsp_write_o`/`rsp_err_o`=0, `rsp_data_o`=0.
  - FSM in IDLE, pointers 0.
- Latency: push accepted at edge E into an empty FIFO while in IDLE. `add_o` carries the command from edge E+1.
- Completion: `ready_i`=1 sampled at edge R gives `rsp_valid_o` high from R to R+1. `add_o`=00 in that same cycle (GAP).
  - If the FIFO is non-empty, the next command is on `add_o` from R+1.
  - Back-to-back commands are therefore separated by exactly one NOP cycle.
- `ready_i` is ignored outside ACTIVE.
- Reset asserted mid-operation:
  - Immediate return to reset values and FIFO flush.
  - In-flight command is lost with no response.
  - `add_o` goes to 00 asynchronously.

## Configuration
- `APB_SEQ_TIMEOUT_EN` defined:
  - A cycle counter is cleared on entry to ACTIVE and increments each ACTIVE cycle.
  - If it reaches `TIMEOUT` with `ready_i` still low, the command is aborted.
  - Abort response: `rsp_valid_o`=1, `rsp_err_o`=1, `rsp_data_o`=0, then state goes to GAP.
  - `rsp_err_o`=0 on normal completion.
- `APB_SEQ_TIMEOUT_EN` undefined:
  - No counter; ACTIVE waits indefinitely.
  - `rsp_err_o` is tied to 0.

## Test plan
- Reset, then single WRITE (`cmd_i`=11, data 0xDEADBEEF):
  - `add_o`=11 and `wdata_o`=0xDEADBEEF from E+1.
  - `ready_i` high at R gives `rsp_valid_o`=1, `rsp_write_o`=1, `rsp_data_o`=0.
- Single READ with `rdata_i`=0x12345678 when `ready_i` rises after 3 wait cycles:
  - `add_o`=01 held for 4 cycles.
  - Response `rsp_data_o`=0x12345678, `rsp_write_o`=0.
- Push DEPTH+1 commands with `ready_i` low:
  - `cmd_ready_o` drops once full (one command active plus DEPTH queued).
  - Release `ready_i` every cycle: all commands complete in order, each separated by one NOP cycle on `add_o`.
- Push `cmd_i`=10 and 00:
  - Handshake accepted, `level_o` unchanged, no `add_o` activity, no response.
- Assert `preset` while in ACTIVE with 2 commands queued:
  - `add_o`=00 immediately, `level_o`=0, no `rsp_valid_o`.
  - After release, a new READ issues normally.
- With `APB_SEQ_TIMEOUT_EN`, `TIMEOUT`=16, `ready_i` held low:
  - After 16 ACTIVE cycles: `rsp_valid_o`=1, `rsp_err_o`=1, `rsp_data_o`=0.
  - The next queued command then issues after one NOP cycle.
